// File: rtl/aes_pkg.sv
// Shared AES-128 constants, types and the GF(2^8) doubling helper used by the
// round controller and its round-constant generator.
package aes_pkg;

  localparam int         NR_AES128 = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1B;

  typedef logic [127:0] aes_block_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_state_e;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register: restarts at 01 when a block is loaded and doubles
// in GF(2^8) once per round while the controller is running.
module aes_rcon_gen
  import aes_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic       i_advance,
  output logic [7:0] o_rcon
);

  logic [7:0] r_rcon;

  // Load has priority so a new block always starts from the first constant.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rcon <= RCON_INIT;
    end else if (i_load) begin
      r_rcon <= RCON_INIT;
    end else if (i_advance) begin
      r_rcon <= xtime(r_rcon);
    end
  end

  assign o_rcon = r_rcon;

endmodule

// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 encryption controller. Holds cipher state, round key and
// round counter, and steps an external combinational round datapath and key
// expansion once per cycle for NR rounds, with valid/ready on both sides.
module aes128_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR      = NR_AES128,
  parameter int ZEROIZE = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [127:0] i_in_data,
  input  logic [127:0] i_in_key,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [127:0] o_out_data,
  output logic         o_busy,
  output logic [127:0] o_rnd_state,
  output logic [127:0] o_rnd_key,
  output logic [7:0]   o_rnd_rcon,
  output logic         o_rnd_last,
  output logic [3:0]   o_rnd_idx,
  input  logic [127:0] i_key_next,
  input  logic [127:0] i_rnd_result
);

  localparam logic [3:0] LP_NR = 4'(NR);

  aes_state_e r_state;
  aes_block_t r_st;
  aes_block_t r_key;
  logic [3:0] r_round;
  logic       r_out_valid;
  logic       r_busy;
  logic       r_last;
  logic       w_accept;
  logic       w_advance;

  // Ready in IDLE, or in DONE when the current result is being taken.
  assign o_in_ready = ~i_rst & ((r_state == IDLE) | ((r_state == DONE) & i_out_ready));
  assign w_accept   = i_in_valid & o_in_ready;
  assign w_advance  = (r_state == RUN);

  aes_rcon_gen u_rcon (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (w_accept),
    .i_advance (w_advance),
    .o_rcon    (o_rnd_rcon)
  );

  // Controller FSM with registered status outputs; a load overrides zeroize.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_st        <= '0;
      r_key       <= '0;
      r_round     <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_last      <= 1'b0;
    end else if (w_accept) begin
      r_state     <= RUN;
      r_st        <= i_in_data ^ i_in_key;
      r_key       <= i_in_key;
      r_round     <= 4'd1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b1;
      r_last      <= (LP_NR == 4'd1);
    end else begin
      case (r_state)
        RUN: begin
          r_st  <= i_rnd_result;
          r_key <= i_key_next;
          if (r_round == LP_NR) begin
            r_state     <= DONE;
            r_round     <= '0;
            r_busy      <= 1'b0;
            r_last      <= 1'b0;
            r_out_valid <= 1'b1;
          end else begin
            r_round <= r_round + 4'd1;
            r_last  <= ((r_round + 4'd1) == LP_NR);
          end
        end
        DONE: begin
          if (i_out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            if (ZEROIZE != 0) begin
              r_st  <= '0;
              r_key <= '0;
            end
          end
        end
        IDLE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_st;
  assign o_busy      = r_busy;
  assign o_rnd_state = r_st;
  assign o_rnd_key   = r_key;
  assign o_rnd_last  = r_last;
  assign o_rnd_idx   = r_busy ? r_round : 4'd0;

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Scoreboard bench for aes128_round_ctrl: provides the AES round datapath and
// key expansion as a behavioural model, plus a full-cipher reference model.
module tb_aes128_round_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic [127:0] rnd_state;
  logic [127:0] rnd_key;
  logic [7:0]   rnd_rcon;
  logic         rnd_last;
  logic [3:0]   rnd_idx;
  logic [127:0] key_next;
  logic [127:0] rnd_result;

  logic ready_man;
  logic ready_rand_en;
  logic r_rand;

  typedef struct {
    logic [127:0] exp;
    int           cyc;
  } sb_t;
  sb_t sbq[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int run_start = 0;
  logic prev_ov  = 1'b0;
  logic zero_chk = 1'b0;

  logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes128_round_ctrl dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_in_data    (in_data),
    .i_in_key     (in_key),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_data   (out_data),
    .o_busy       (busy),
    .o_rnd_state  (rnd_state),
    .o_rnd_key    (rnd_key),
    .o_rnd_rcon   (rnd_rcon),
    .o_rnd_last   (rnd_last),
    .o_rnd_idx    (rnd_idx),
    .i_key_next   (key_next),
    .i_rnd_result (rnd_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) r_rand <= ($urandom_range(0, 3) != 0);
  assign out_ready = ready_rand_en ? r_rand : ready_man;

  // ---------------- AES behavioural model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] r, sq, v;
    int e;
    r = 8'h01; sq = b; e = 254;
    while (e != 0) begin
      if (e % 2 == 1) r = gmul(r, sq);
      sq = gmul(sq, sq);
      e = e / 2;
    end
    v = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    return v;
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] blk, input int i);
    return blk[127 - 8*i -: 8];
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    n0 = w0 ^ t; n1 = w1 ^ n0; n2 = w2 ^ n1; n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [127:0] t, m;
    logic [7:0] a0, a1, a2, a3;
    t = '0;
    for (int i = 0; i < 16; i++)
      t[127 - 8*i -: 8] = sbox(gb(s, (i % 4) + 4 * (((i / 4) + (i % 4)) % 4)));
    m = t;
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = gb(t, 4*c); a1 = gb(t, 4*c+1); a2 = gb(t, 4*c+2); a3 = gb(t, 4*c+3);
        m[127 - 32*c      -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        m[127 - 32*c - 8  -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        m[127 - 32*c - 16 -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        m[127 - 32*c - 24 -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    return m ^ k;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] rk [11];
    logic [127:0] s;
    logic [7:0] rc;
    rk[0] = key; rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      rk[r] = key_step(rk[r-1], rc);
      rc = gmul(rc, 8'h02);
    end
    s = pt ^ key;
    for (int r = 1; r <= 10; r++) s = aes_round(s, rk[r], r == 10);
    return s;
  endfunction

  // External combinational datapath seen by the controller
  always_comb begin
    key_next   = key_step(rnd_key, rnd_rcon);
    rnd_result = aes_round(rnd_state, key_next, rnd_last);
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Monitor: samples on the falling edge and compares against the scoreboard
  always @(negedge clk) begin
    int ei;
    if (rst) begin
      check("reset_ctrl", {in_ready, out_valid, busy, rnd_last, rnd_idx, rnd_rcon},
            {1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h01});
      check("reset_state", rnd_state, '0);
      check("reset_key", rnd_key, '0);
      sbq.delete();
      prev_ov  = 1'b0;
      zero_chk = 1'b0;
    end else begin
      if (zero_chk) begin
        check("zeroize_state", rnd_state, '0);
        check("zeroize_key", rnd_key, '0);
        zero_chk = 1'b0;
      end
      if (busy) begin
        ei = cyc - run_start;
        check("run_in_ready", in_ready, 0);
        check("run_out_valid", out_valid, 0);
        check("rnd_idx", rnd_idx, 128'(ei));
        check("rnd_last", rnd_last, (ei == 10) ? 1 : 0);
        if (ei >= 1 && ei <= 10) check("rnd_rcon", rnd_rcon, rcon_tab[ei-1]);
      end else begin
        check("idle_idx_last", {rnd_last, rnd_idx}, 0);
        if (!out_valid) check("idle_in_ready", in_ready, 1);
      end
      if (out_valid && !prev_ov) begin
        if (sbq.size() == 0) check("no_spurious_out_valid", out_valid, 0);
        else check("latency", 128'(cyc), 128'(sbq[0].cyc + 11));
      end
      if (out_valid && sbq.size() > 0) begin
        check("out_data", out_data, sbq[0].exp);
        check("done_in_ready", in_ready, out_ready);
        if (out_ready) begin
          void'(sbq.pop_front());
          zero_chk = !in_valid;
        end
      end
      prev_ov = out_valid;
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] key, input logic [127:0] pt,
                      input logic [127:0] exp, input int garbage);
    logic acc;
    sb_t e;
    acc = 1'b0;
    in_valid = 1'b1; in_data = pt; in_key = key;
    for (int n = 0; n < 400 && !acc; n++) begin
      @(negedge clk);
      if (in_ready) begin
        e.exp = exp; e.cyc = cyc;
        sbq.push_back(e);
        run_start = cyc;
        acc = 1'b1;
      end
      step();
    end
    if (!acc) timeout_fail("accept_wait");
    for (int g = 0; g < garbage; g++) begin
      in_valid = 1'b1; in_data = rand128(); in_key = rand128();
      step();
    end
    in_valid = 1'b0; in_data = rand128(); in_key = rand128();
  endtask

  task automatic drain();
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 600 && !ok; n++) begin
      step();
      if (sbq.size() == 0 && !out_valid) ok = 1'b1;
    end
    if (!ok) timeout_fail("drain_wait");
  endtask

  initial begin
    logic [127:0] k, p;
    logic ok;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_key = '0;
    ready_man = 1'b1; ready_rand_en = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Known answers, second with garbage offered during RUN
    send(KB, PB, CB, 0);
    drain();
    send(KC, PC, CC, 8);
    drain();

    // Back-pressure: hold OUT_READY low five cycles with IN_VALID offered
    ready_man = 1'b0;
    k = rand128(); p = rand128();
    send(k, p, aes_ref(p, k), 0);
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      step();
      if (out_valid) ok = 1'b1;
    end
    if (!ok) timeout_fail("out_valid_wait");
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = rand128(); in_key = rand128();
      step();
    end
    in_valid = 1'b0;
    ready_man = 1'b1;
    drain();
    repeat (2) step();

    // Back-to-back with IN_VALID held high
    send(KB, PB, CB, 0);
    send(KC, PC, CC, 0);
    drain();

    // Reset in the middle of a block
    k = rand128(); p = rand128();
    send(k, p, aes_ref(p, k), 0);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      if (rnd_idx == 4'd5) ok = 1'b1;
      else step();
    end
    if (!ok) timeout_fail("round5_wait");
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (15) step();
    send(KB, PB, CB, 0);
    drain();

    // Randomised blocks with random back-pressure and garbage offers
    ready_rand_en = 1'b1;
    for (int b = 0; b < 16; b++) begin
      repeat ($urandom_range(0, 3)) step();
      k = rand128(); p = rand128();
      send(k, p, aes_ref(p, k), $urandom_range(0, 6));
    end
    drain();
    ready_rand_en = 1'b0;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
